// File: rtl/poly_chord_player.sv
// poly_chord_player
//
// Polyphonic square-wave chord player. Each of NUM_VOICES voices holds a note and a
// duration countdown and produces a square tone. The tones are summed, saturated and
// registered into one signed audio sample. A sticky song-done flag blocks new notes and
// raises done_out once every voice has drained.
//
// Optional feature (compile-time macro POLY_CHORD_VOICE_MUTE_EN):
//   adds mute_in; a muted voice is left out of the mix but otherwise keeps running.
//
// Ports:
//   clk_in                 system clock
//   rst_in                 asynchronous active-high reset
//   note_in                per-voice note, voice i at [i*NOTE_W +: NOTE_W], 0 = rest
//   duration_in            per-voice duration, same packing
//   new_note_in            per-voice one-cycle load strobe
//   time_advance_in        elapsed time units
//   time_advance_ready_in  one-cycle strobe qualifying time_advance_in
//   song_done_in           end-of-song indication (level or pulse)
//   mute_in                per-voice mute (only with POLY_CHORD_VOICE_MUTE_EN)
//   audio_out              signed mixed sample, one cycle behind the voice state
//   voice_active_out       per-voice busy flags
//   done_out               song finished and all voices idle (sticky until reset)

module poly_chord_player #(
    parameter int unsigned NUM_VOICES   = 3,
    parameter int unsigned NOTE_W       = 6,
    parameter int unsigned DUR_W        = 6,
    parameter int unsigned PERIOD_SHIFT = 4,
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned AMPLITUDE    = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_VOICES*NOTE_W-1:0] note_in,
    input  logic [NUM_VOICES*DUR_W-1:0]  duration_in,
    input  logic [NUM_VOICES-1:0]        new_note_in,
    input  logic [DUR_W-1:0]             time_advance_in,
    input  logic                         time_advance_ready_in,
    input  logic                         song_done_in,
`ifdef POLY_CHORD_VOICE_MUTE_EN
    input  logic [NUM_VOICES-1:0]        mute_in,
`endif
    output logic signed [SAMPLE_W-1:0]   audio_out,
    output logic [NUM_VOICES-1:0]        voice_active_out,
    output logic                         done_out
);

    // Tone counter must hold ((2^NOTE_W) << PERIOD_SHIFT) - 1.
    localparam int unsigned CNT_W = NOTE_W + PERIOD_SHIFT;

    localparam logic signed [31:0] AMP_POS = 32'(AMPLITUDE);
    localparam logic signed [31:0] AMP_NEG = -32'(AMPLITUDE);
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SAMPLE_W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (SAMPLE_W - 1));

    typedef enum logic {
        StIdle,
        StPlaying
    } voice_state_t;

    logic                       r_song_done;
    logic                       r_done;
    logic signed [SAMPLE_W-1:0] r_audio;

    logic                       w_song_done;
    logic                       w_all_idle;
    logic [NUM_VOICES-1:0]      w_active;
    logic [NUM_VOICES-1:0]      w_mute;
    logic signed [31:0]         w_contrib [NUM_VOICES];
    logic signed [31:0]         w_sum;
    logic signed [SAMPLE_W-1:0] w_sample;

    // Including the live input lets a song_done_in that arrives while everything is idle
    // raise done_out on the very next edge, and keeps a same-cycle load from racing it.
    assign w_song_done = r_song_done | song_done_in;
    assign w_all_idle  = ~|w_active;

`ifdef POLY_CHORD_VOICE_MUTE_EN
    assign w_mute = mute_in;
`else
    assign w_mute = '0;
`endif

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        voice_state_t      r_state;
        logic [NOTE_W-1:0] r_note;
        logic [DUR_W-1:0]  r_remain;
        logic [CNT_W-1:0]  r_tone_cnt;
        logic              r_level;

        logic [NOTE_W-1:0] w_note_slice;
        logic [DUR_W-1:0]  w_dur_slice;
        logic              w_load;
        logic [CNT_W:0]    w_half;
        logic              w_wrap;
        logic [DUR_W-1:0]  w_step;

        assign w_note_slice = note_in[gi*NOTE_W +: NOTE_W];
        assign w_dur_slice  = duration_in[gi*DUR_W +: DUR_W];
        assign w_load       = new_note_in[gi] & ~w_song_done;

        // Half period in cycles: (note + 1) << PERIOD_SHIFT.
        assign w_half = ((CNT_W + 1)'(r_note) + (CNT_W + 1)'(1)) << PERIOD_SHIFT;
        assign w_wrap = ({1'b0, r_tone_cnt} == (w_half - (CNT_W + 1)'(1)));

        // Clamp the advance so the countdown stops at zero instead of wrapping.
        assign w_step = (time_advance_in < r_remain) ? time_advance_in : r_remain;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_state    <= StIdle;
                r_note     <= '0;
                r_remain   <= '0;
                r_tone_cnt <= '0;
                r_level    <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_load && (w_dur_slice != '0)) begin
                            r_state    <= StPlaying;
                            r_note     <= w_note_slice;
                            r_remain   <= w_dur_slice;
                            r_tone_cnt <= '0;
                            r_level    <= 1'b1;
                        end
                    end
                    StPlaying: begin
                        if (w_load) begin
                            // Retrigger restarts the tone from the high half; a zero
                            // duration silences the voice instead.
                            if (w_dur_slice != '0) begin
                                r_note     <= w_note_slice;
                                r_remain   <= w_dur_slice;
                                r_tone_cnt <= '0;
                                r_level    <= 1'b1;
                            end else begin
                                r_state  <= StIdle;
                                r_remain <= '0;
                            end
                        end else begin
                            if (r_note != '0) begin
                                if (w_wrap) begin
                                    r_tone_cnt <= '0;
                                    r_level    <= ~r_level;
                                end else begin
                                    r_tone_cnt <= r_tone_cnt + 1'b1;
                                end
                            end
                            if (time_advance_ready_in) begin
                                r_remain <= r_remain - w_step;
                                // remain is never 0 while playing, so this only fires
                                // when the advance uses up the rest of the note.
                                if (r_remain == w_step) begin
                                    r_state <= StIdle;
                                end
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end

        assign w_active[gi] = (r_state == StPlaying);

        assign w_contrib[gi] = (w_active[gi] && (r_note != '0) && !w_mute[gi])
                             ? (r_level ? AMP_POS : AMP_NEG)
                             : 32'sd0;
    end

    // Mix at full width, then saturate into the sample range.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + w_contrib[i];
        end
        if (w_sum > SAT_MAX) begin
            w_sample = SAT_MAX[SAMPLE_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sample = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            w_sample = w_sum[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_song_done <= 1'b0;
            r_done      <= 1'b0;
            r_audio     <= '0;
        end else begin
            r_song_done <= w_song_done;
            r_done      <= r_done | (w_song_done & w_all_idle);
            r_audio     <= w_sample;
        end
    end

    assign audio_out        = r_audio;
    assign voice_active_out = w_active;
    assign done_out         = r_done;

endmodule

// File: tb/tb_poly_chord_player.sv
// Self-checking bench for poly_chord_player. Two instances share the stimulus: one with
// AMPLITUDE=32 and one with AMPLITUDE=64 to exercise saturation. A behavioural model
// tracks each voice as (playing, note, remaining, edges since load) and derives the
// square level from elapsed time arithmetically.

module tb_poly_chord_player;

    localparam int NV     = 3;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int PS     = 4;
    localparam int SW     = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NV*NOTE_W-1:0]     note;
    logic [NV*DUR_W-1:0]      dur;
    logic [NV-1:0]            nn;
    logic [DUR_W-1:0]         ta;
    logic                     ta_rdy;
    logic                     sd;
`ifdef POLY_CHORD_VOICE_MUTE_EN
    logic [NV-1:0]            mute;
`endif

    logic signed [SW-1:0]     audio;
    logic signed [SW-1:0]     audio64;
    logic [NV-1:0]            active;
    logic [NV-1:0]            active64;
    logic                     done;
    logic                     done64;

    always #5 clk = ~clk;

    poly_chord_player #(
        .NUM_VOICES  (NV),
        .NOTE_W      (NOTE_W),
        .DUR_W       (DUR_W),
        .PERIOD_SHIFT(PS),
        .SAMPLE_W    (SW),
        .AMPLITUDE   (32)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .note_in              (note),
        .duration_in          (dur),
        .new_note_in          (nn),
        .time_advance_in      (ta),
        .time_advance_ready_in(ta_rdy),
        .song_done_in         (sd),
`ifdef POLY_CHORD_VOICE_MUTE_EN
        .mute_in              (mute),
`endif
        .audio_out            (audio),
        .voice_active_out     (active),
        .done_out             (done)
    );

    poly_chord_player #(
        .NUM_VOICES  (NV),
        .NOTE_W      (NOTE_W),
        .DUR_W       (DUR_W),
        .PERIOD_SHIFT(PS),
        .SAMPLE_W    (SW),
        .AMPLITUDE   (64)
    ) dut_sat (
        .clk_in               (clk),
        .rst_in               (rst),
        .note_in              (note),
        .duration_in          (dur),
        .new_note_in          (nn),
        .time_advance_in      (ta),
        .time_advance_ready_in(ta_rdy),
        .song_done_in         (sd),
`ifdef POLY_CHORD_VOICE_MUTE_EN
        .mute_in              (mute),
`endif
        .audio_out            (audio64),
        .voice_active_out     (active64),
        .done_out             (done64)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit m_play [NV];
    int m_note [NV];
    int m_rem  [NV];
    int m_n    [NV];
    bit m_flag;
    bit m_done;
    int e_audio32;
    int e_audio64;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Net count of high (+1) and low (-1) sounding voices.
    function automatic int sign_sum();
        int s = 0;
        for (int v = 0; v < NV; v++) begin
            bit muted = 1'b0;
`ifdef POLY_CHORD_VOICE_MUTE_EN
            muted = mute[v];
`endif
            if (m_play[v] && m_note[v] != 0 && !muted) begin
                int half = (m_note[v] + 1) << PS;
                s += (((m_n[v] / half) % 2) == 0) ? 1 : -1;
            end
        end
        return s;
    endfunction

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = m_play[v];
        return a;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_play[v] = 1'b0;
            m_note[v] = 0;
            m_rem[v]  = 0;
            m_n[v]    = 0;
        end
        m_flag    = 1'b0;
        m_done    = 1'b0;
        e_audio32 = 0;
        e_audio64 = 0;
    endtask

    task automatic clear_inputs();
        nn     = '0;
        ta     = '0;
        ta_rdy = 1'b0;
        sd     = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("active", 32'(active), 32'(model_active()));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("audio", 32'(audio), e_audio32);
        check_eq("audio_sat", 32'(audio64), e_audio64);
        check_eq("active_sat", 32'(active64), 32'(model_active()));
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic tick();
        int  s;
        bit  idle;
        bit  sdv;
        @(posedge clk);
        s         = sign_sum();
        e_audio32 = sat(s * 32);
        e_audio64 = sat(s * 64);
        idle = 1'b1;
        for (int v = 0; v < NV; v++) if (m_play[v]) idle = 1'b0;
        sdv    = m_flag || sd;
        m_done = m_done || (sdv && idle);
        m_flag = sdv;
        for (int v = 0; v < NV; v++) begin
            int d  = int'(dur[v*DUR_W +: DUR_W]);
            int nt = int'(note[v*NOTE_W +: NOTE_W]);
            if (nn[v] && !sdv) begin
                if (d != 0) begin
                    m_play[v] = 1'b1;
                    m_note[v] = nt;
                    m_rem[v]  = d;
                    m_n[v]    = 0;
                end else begin
                    m_play[v] = 1'b0;
                    m_rem[v]  = 0;
                end
            end else if (m_play[v]) begin
                m_n[v]++;
                if (ta_rdy) begin
                    int a = int'(ta);
                    m_rem[v] -= (a < m_rem[v]) ? a : m_rem[v];
                    if (m_rem[v] == 0) m_play[v] = 1'b0;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int v, input int nt, input int d);
        nn[v]                    = 1'b1;
        note[v*NOTE_W +: NOTE_W] = NOTE_W'(nt);
        dur[v*DUR_W +: DUR_W]    = DUR_W'(d);
    endtask

    task automatic advance(input int a);
        ta     = DUR_W'(a);
        ta_rdy = 1'b1;
    endtask

    // Called just after tick(); the reset pulse falls between clock edges.
    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_audio", 32'(audio), 0);
        check_eq("rst_active", 32'(active), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_audio_sat", 32'(audio64), 0);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        note = '0;
        dur  = '0;
`ifdef POLY_CHORD_VOICE_MUTE_EN
        mute = '0;
`endif
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Single voice, toggling tone, then drained by two advances.
        ticks(2);
        load(0, 1, 5);
        tick();
        clear_inputs();
        check_eq("t1_active", 32'(active), 1);
        ticks(32);
        check_eq("t1_high", 32'(audio), 32);
        tick();
        check_eq("t1_low", 32'(audio), -32);
        advance(3);
        tick();
        tick();
        clear_inputs();
        check_eq("t1_idle", 32'(active), 0);
        tick();
        check_eq("t1_silent", 32'(audio), 0);

        // Three voices high together, then low together.
        load(0, 2, 40);
        load(1, 2, 40);
        load(2, 2, 40);
        tick();
        clear_inputs();
        tick();
        check_eq("t2_sum", 32'(audio), 96);
        check_eq("t2_sat_hi", 32'(audio64), 127);
        ticks(48);
        check_eq("t2_neg", 32'(audio), -96);
        check_eq("t2_sat_lo", 32'(audio64), -128);
        for (int v = 0; v < NV; v++) load(v, 0, 0);
        tick();
        clear_inputs();
        check_eq("t2_zero_dur", 32'(active), 0);

        // Retrigger wins over a same-cycle advance for that voice only.
        load(0, 1, 10);
        load(1, 1, 6);
        tick();
        clear_inputs();
        advance(4);
        tick();
        load(1, 1, 10);
        advance(4);
        tick();
        clear_inputs();
        check_eq("t3_both", 32'(active), 3);
        advance(2);
        tick();
        clear_inputs();
        check_eq("t3_v1_only", 32'(active), 2);

        // Oversized advance clamps to zero.
        advance(63);
        tick();
        clear_inputs();
        check_eq("t4_clamp_v1", 32'(active), 0);
        load(2, 3, 5);
        tick();
        clear_inputs();
        advance(63);
        tick();
        clear_inputs();
        tick();
        check_eq("t4_no_wrap", 32'(active), 0);

        // Song completion blocks new notes and latches done.
        load(0, 1, 8);
        load(2, 1, 12);
        tick();
        clear_inputs();
        sd = 1'b1;
        tick();
        clear_inputs();
        load(1, 1, 5);
        tick();
        clear_inputs();
        check_eq("t5_blocked", 32'(active), 5);
        advance(8);
        tick();
        clear_inputs();
        check_eq("t5_v2_left", 32'(active), 4);
        check_eq("t5_not_done", 32'(done), 0);
        advance(4);
        tick();
        clear_inputs();
        check_eq("t5_drained", 32'(done), 0);
        tick();
        check_eq("t5_done", 32'(done), 1);
        for (int v = 0; v < NV; v++) load(v, 1, 9);
        tick();
        clear_inputs();
        ticks(3);
        check_eq("t5_hold", 32'(done), 1);
        check_eq("t5_still_idle", 32'(active), 0);
        async_reset_pulse();

        // Song done while idle gives done on the next edge.
        sd = 1'b1;
        tick();
        clear_inputs();
        check_eq("t5_idle_done", 32'(done), 1);
        async_reset_pulse();

        // Reset in the middle of a sounding note.
        load(0, 1, 20);
        tick();
        clear_inputs();
        ticks(3);
        check_eq("t6_sounding", 32'(audio), 32);
        async_reset_pulse();
        tick();

`ifdef POLY_CHORD_VOICE_MUTE_EN
        load(0, 1, 20);
        mute = 3'b001;
        tick();
        clear_inputs();
        tick();
        check_eq("mute_audio", 32'(audio), 0);
        check_eq("mute_active", 32'(active), 1);
        mute = '0;
        tick();
        async_reset_pulse();
`endif

        // Randomised episodes checked cycle by cycle against the model.
        for (int ep = 0; ep < 3; ep++) begin
            int  sd_at   = $urandom_range(400, 600);
            bit  sd_hold = 1'($urandom_range(0, 1));
            for (int cyc = 0; cyc < 800; cyc++) begin
                clear_inputs();
                for (int v = 0; v < NV; v++) begin
                    if ($urandom_range(0, 15) == 0) begin
                        load(v, $urandom_range(0, 3),
                             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
                    end
                end
                if ($urandom_range(0, 9) == 0) begin
                    advance(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                                         : $urandom_range(0, 8));
                end
                sd = (cyc == sd_at) || (sd_hold && cyc > sd_at);
`ifdef POLY_CHORD_VOICE_MUTE_EN
                if (cyc % 50 == 0) mute = NV'($urandom_range(0, 7));
`endif
                tick();
            end
            clear_inputs();
            async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_chord_player.md
Name: poly_chord_player

Overview:
- Parametrised successor to the fixed three-voice chord player: NUM_VOICES independent voices, each with its own note, duration and countdown.
- Each voice generates a square tone; the voices are summed into one signed audio sample for the audio output stage.
- Sits between song_reader, which supplies notes, durations and time_advance, and the audio output stage.
- Tracks song completion and reports when every voice has drained.

Parameters:
- NUM_VOICES, 3, number of voices (1..8).
- NOTE_W, 6, note index width; note 0 = rest.
- DUR_W, 6, duration and time_advance width.
- PERIOD_SHIFT, 4, tone half-period = (note+1) << PERIOD_SHIFT cycles.
- SAMPLE_W, 8, signed mixed-sample width.
- AMPLITUDE, 32, per-voice contribution magnitude.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- note_in  input  NUM_VOICES*NOTE_W  per-voice note; voice i occupies bits [i*NOTE_W +: NOTE_W].
- duration_in  input  NUM_VOICES*DUR_W  per-voice duration, same packing.
- new_note_in  input  NUM_VOICES  per-voice one-cycle load strobe.
- time_advance_in  input  DUR_W  elapsed time units.
- time_advance_ready_in  input  1  one-cycle strobe qualifying time_advance_in.
- song_done_in  input  1  level or pulse; end of song.
- audio_out  output  SAMPLE_W  signed mixed sample.
- voice_active_out  output  NUM_VOICES  per-voice busy flags.
- done_out  output  1  song finished and all voices idle.

Behaviour:
- Reset: the asynchronous rst_in clears every register.
  - audio_out=0, voice_active_out=0, done_out=0.
  - All countdowns, tone counters and square levels = 0; the latched song_done flag = 0.
- Per-voice FSM, two states: IDLE and PLAYING.
  - IDLE -> PLAYING: new_note_in[i]=1, song_done flag clear, and duration_in slice != 0. Latch note and duration; clear the tone counter; square level = 1.
  - Duration 0 on load: the voice stays or becomes IDLE.
  - PLAYING + new_note_in[i]: reload note and duration (retrigger); clear the tone counter.
  - PLAYING + time_advance_ready_in: remaining -= min(time_advance_in, remaining), so the countdown never underflows. On reaching 0, go to IDLE on the next edge.
  - Same-cycle new_note_in[i] and time_advance_ready_in: the load wins for voice i and the advance is ignored for that voice. Other voices still advance.
  - time_advance_in = 0: no change.
- Tone generation in PLAYING with note != 0:
  - The counter counts up to (note+1)<<PERIOD_SHIFT - 1, then wraps to 0 and toggles the square level.
  - Note 0 (rest): the voice stays PLAYING, counts down, and contributes 0.
- Mixer:
  - Each PLAYING, non-rest voice contributes +AMPLITUDE when its square level is 1, and -AMPLITUDE when 0. IDLE voices contribute 0.
  - The sum is formed at full width, then saturated to [-(2^(SAMPLE_W-1)), 2^(SAMPLE_W-1)-1].
  - audio_out is registered: 1-cycle latency from voice state to output.
- voice_active_out[i] = 1 exactly while voice i is PLAYING; registered, with no extra latency beyond the state register.
- Song completion:
  - song_done_in is sticky: it sets a flag on first assertion, and the flag is cleared only by reset.
  - With the flag set, new_note_in is ignored; voices already PLAYING finish their counts.
  - done_out = flag AND all voices IDLE, registered. Once set it stays 1 until reset.
  - song_done_in arriving while everything is idle gives done_out=1 on the next edge.
- Reset asserted mid-note: immediate return to the reset values; no partial sample is emitted.

Optional Feature:
- Macro: POLY_CHORD_VOICE_MUTE_EN.
- Defined: adds input mute_in [NUM_VOICES-1:0].
  - A muted voice contributes 0 to the mix.
  - Its FSM, countdown, tone counter and voice_active_out bit continue unchanged.
  - Mute takes effect on the sample registered at the next edge.
- Undefined: no mute_in port, and all voices are always mixed.

Test Plan:
1. Reset release, then voice0 note=1, duration=5 -> voice_active_out=001 next edge. audio_out toggles +32/-32 every 32 cycles. After time_advance 3 then 3, the voice goes idle and audio_out returns to 0.
2. Three voices loaded together, all square levels high -> audio_out=96. Same test with AMPLITUDE=64 -> saturates at 127 (and at -128 when all are low).
3. Same-cycle new_note_in[1] (duration 10) and time_advance_ready with advance 4 while voice1 is playing remaining=2 -> voice1 remaining=10. Voice0 (remaining 6) -> 2.
4. Advance 63 on a voice with remaining=5 -> remaining clamps to 0, voice goes IDLE, no wrap to a large value.
5. Voices 0 and 2 playing, song_done_in pulse, then new_note_in[1] -> voice1 stays idle. done_out rises one edge after the last voice idles and holds until reset.
6. Asynchronous rst_in pulse mid-note, not clock-aligned -> all outputs 0 immediately. With POLY_CHORD_VOICE_MUTE_EN and mute_in=001 on a sounding voice0 -> audio_out=0 while voice_active_out[0]=1.
